// File: rtl/core_pkg.sv
// Shared LSU types: access size, FSM state and the captured request record.
// No logic; pure declarations plus the misalignment rule.
// No flow control of its own.
package core_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE    = 2'd0,
        LSU_HALF    = 2'd1,
        LSU_WORD    = 2'd2,
        LSU_ILLEGAL = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        lsu_size_e   size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd_addr;
    } lsu_req_t;

    // Size 3 is treated as an always-misaligned access so it never reaches memory.
    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
        case (size)
            LSU_BYTE: return 1'b0;
            LSU_HALF: return off[0];
            LSU_WORD: return off != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Alignment datapath: misalign check, byte enables, store lane replication, load extraction.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module core_lsu_align
    import core_pkg::*;
(
    input  lsu_size_e   chk_size,
    input  logic [1:0]  chk_off,
    output logic        chk_misaligned,
    input  lsu_size_e   size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign chk_misaligned = lsu_misaligned(chk_size, chk_off);
    assign shifted        = rdata >> {off, 3'b000};

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (size)
            LSU_BYTE: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            LSU_HALF: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            LSU_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one outstanding access on the data-memory req/grnt/rvalid port.
// Store completes on grant (1 cycle after accept); load writes back 1 cycle after rvalid.
// req_ready_o only in IDLE; stall_o held while an access is in flight; timeout aborts a stuck access.
module core_lsu
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_addr_i,
    output logic        data_mem_req_o,
    input  logic        data_mem_grnt_i,
    output logic [31:0] data_mem_addr_o,
    output logic [31:0] data_mem_wdata_o,
    output logic [3:0]  data_mem_be_o,
    output logic        data_mem_ren_o,
    output logic        data_mem_wen_o,
    input  logic [31:0] data_mem_rdata_i,
    input  logic        data_mem_rvalid_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_data_o,
    output logic        store_done_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        stall_o
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on the cycle it sits there.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);

    lsu_state_e  state;
    lsu_req_t    req_q;
    logic [TW-1:0] tmo_cnt;

    logic        in_req;
    logic        tmo_hit;
    logic        req_misaligned;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;

    core_lsu_align u_align (
        .chk_size       (lsu_size_e'(req_size_i)),
        .chk_off        (req_addr_i[1:0]),
        .chk_misaligned (req_misaligned),
        .size           (req_q.size),
        .off            (req_q.addr[1:0]),
        .is_unsigned    (req_q.is_unsigned),
        .wdata          (req_q.wdata),
        .rdata          (data_mem_rdata_i),
        .be             (be),
        .wdata_rep      (wdata_rep),
        .rdata_ext      (rdata_ext)
    );

    assign in_req  = (state == REQ);
    assign tmo_hit = TMO_EN && (state != IDLE) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            req_q        <= '0;
            tmo_cnt      <= '0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            wb_rd_addr_o <= '0;
        end else begin
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            wb_valid_o   <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (req_valid_i) begin
                        req_q.we          <= req_we_i;
                        req_q.size        <= lsu_size_e'(req_size_i);
                        req_q.is_unsigned <= req_unsigned_i;
                        req_q.addr        <= req_addr_i;
                        req_q.wdata       <= req_wdata_i;
                        req_q.rd_addr     <= req_rd_addr_i;
                        if (req_misaligned) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A grant on the last allowed cycle still wins over the abort.
                    if (data_mem_grnt_i) begin
                        state   <= req_q.we ? IDLE : RESP;
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        state     <= IDLE;
                        bus_err_o <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: begin
                    if (data_mem_rvalid_i) begin
                        wb_valid_o   <= 1'b1;
                        wb_data_o    <= rdata_ext;
                        wb_rd_addr_o <= req_q.rd_addr;
                        state        <= IDLE;
                        tmo_cnt      <= '0;
                    end else if (tmo_hit) begin
                        state     <= IDLE;
                        bus_err_o <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

    assign req_ready_o      = (state == IDLE);
    assign data_mem_req_o   = in_req;
    assign data_mem_addr_o  = in_req ? {req_q.addr[31:2], 2'b00} : 32'd0;
    assign data_mem_wdata_o = in_req ? wdata_rep : 32'd0;
    assign data_mem_be_o    = in_req ? be : 4'b0000;
    assign data_mem_ren_o   = in_req & ~req_q.we;
    assign data_mem_wen_o   = in_req & req_q.we;
    assign store_done_o     = in_req & data_mem_grnt_i & req_q.we;
    assign stall_o          = (state != IDLE) || (req_valid_i && !req_misaligned);

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Load/store unit that sits directly downstream of core_execution and drives the core's data-memory port. It takes one memory request at a time: the address from the ALU result, plus size, sign, store data and destination register. It performs alignment, byte-enable generation and the req/grnt/rvalid handshake. For loads it returns sign- or zero-extended data to core_writeback, and it asserts stall while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ or RESP before the transaction is aborted with bus_err_o; 0 disables the timeout.

Ports:
clk_i  in  1  core clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  execution presents a memory op
req_ready_o  out  1  LSU can accept (state IDLE)
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  core_pkg::lsu_size_e: 0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned_i  in  1  zero-extend load (LBU/LHU)
req_addr_i  in  32  byte address (ALU result)
req_wdata_i  in  32  store data, LSB-aligned
req_rd_addr_i  in  5  load destination register
data_mem_req_o  out  1  memory request
data_mem_grnt_i  in  1  request accepted this cycle
data_mem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}
data_mem_wdata_o  out  32  lane-replicated store data
data_mem_be_o  out  4  byte enables
data_mem_ren_o  out  1  read strobe
data_mem_wen_o  out  1  write strobe
data_mem_rdata_i  in  32  read data
data_mem_rvalid_i  in  1  read data valid
wb_valid_o  out  1  one-cycle pulse: load result valid
wb_rd_addr_o  out  5  load destination
wb_data_o  out  32  extended load data
store_done_o  out  1  one-cycle pulse on store grant
misaligned_o  out  1  one-cycle pulse: misaligned or illegal access
bus_err_o  out  1  one-cycle pulse: timeout abort
stall_o  out  1  pipeline stall request

Behaviour:
- Reset (rst_i sampled high): state IDLE; all outputs 0 except req_ready_o = 1; timeout counter 0; captured request cleared. Reset mid-transaction abandons it, and data_mem_req_o is low the cycle after reset.
- FSM states are IDLE, REQ, RESP.
  - IDLE: req_ready_o = 1. On req_valid_i, capture all req_* fields.
    - Misaligned (half with addr[0] = 1; word with addr[1:0] != 0; size 3): pulse misaligned_o next cycle and stay in IDLE. No memory access occurs.
    - Otherwise: go to REQ.
  - REQ: data_mem_req_o = 1, and ren/wen = ~we/we. addr, wdata and be are held stable until grant.
    - On data_mem_grnt_i with a store: go to IDLE and pulse store_done_o the same cycle.
    - On data_mem_grnt_i with a load: go to RESP.
  - RESP: data_mem_req_o = 0. On data_mem_rvalid_i, register the extended data. wb_valid_o, wb_data_o and wb_rd_addr_o are valid the next cycle, and the state returns to IDLE.
- data_mem_rvalid_i is ignored outside RESP, including a late response after reset or abort. Grant and rvalid in the same cycle is not legal; rvalid arrives at least 1 cycle after grant.
- Byte enables and write data:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}
  - word: be = 4'b1111; wdata unchanged
- Load extraction: shift rdata right by 8*addr[1:0]. Take [7:0] or [15:0], then sign- or zero-extend per req_unsigned_i. A word load is passed through unchanged.
- Timeout: the counter increments each cycle in REQ or RESP and clears on a state change. When it reaches TIMEOUT_CYCLES: drop req, pulse bus_err_o, go to IDLE, and produce no wb_valid_o.
- stall_o = (state != IDLE) || (req_valid_i && accepted && not misaligned).
- Best-case latency:
  - load: accept in cycle 0, req in cycle 1 with grant in cycle 1, rvalid in cycle 2, wb_valid_o in cycle 3.
  - store: accept in cycle 0, req and grant in cycle 1, store_done_o in cycle 1.

Decomposition:
- core_pkg: lsu_size_e (LSU_BYTE, LSU_HALF, LSU_WORD, LSU_ILLEGAL), lsu_state_e (IDLE, REQ, RESP), and a struct lsu_req_t bundling we/size/unsigned/addr/wdata/rd_addr.
- One combinational sub-module, core_lsu_align: misalign detect, be/wdata generation, rdata extraction and extension. The FSM, capture register and timeout counter stay in core_lsu.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, grant on first REQ cycle -> addr_o 0x100, be 4'b1111, wen 1, store_done_o pulse in cycle 1, req_ready_o high in cycle 2.
2. LB addr 0x203, rdata 0x80FF_FF7F returned 2 cycles after grant -> be 4'b1000, wb_data_o 0xFFFF_FF80, rd 5 echoed, single wb_valid_o pulse.
3. LHU addr 0x202, rdata 0x8001_1234 -> be 4'b1100, wb_data_o 0x0000_8001; the same access as LH -> 0xFFFF_8001.
4. SH addr 0x101 -> misaligned_o pulse, no data_mem_req_o; size 3 at addr 0x0 -> misaligned_o pulse.
5. Grant withheld 3 cycles -> addr, be and wdata held stable throughout; TIMEOUT_CYCLES = 4 with no rvalid -> bus_err_o pulse, no wb_valid_o, and a later stray rvalid is ignored.
6. rst_i asserted while in RESP, then rvalid arrives -> outputs reset, no wb_valid_o, next request completes normally.
